// File: rtl/sd_mod_nsel_if.sv
// Sample/select bus of the sigma-delta modulator: input words, select
// handshake, clock enable, saturation flag and the output bitstream.
interface sd_mod_nsel_if #(
   parameter int BITWIDTH = 40,
   parameter int NSEL     = 4
);
   localparam int SW = (NSEL > 1) ? $clog2(NSEL) : 1;

   logic                     en;
   logic [NSEL*BITWIDTH-1:0] kin;
   logic [SW-1:0]            sel;
   logic                     sel_valid;
   logic                     sel_ready;
   logic                     sat_clr;
   logic                     sat_flag;
   logic                     sd_out;

   modport master (
      output en, kin, sel, sel_valid, sat_clr,
      input  sel_ready, sat_flag, sd_out
   );

   modport slave (
      input  en, kin, sel, sel_valid, sat_clr,
      output sel_ready, sat_flag, sd_out
   );
endinterface

// File: rtl/sd_mod_nsel.sv
// 1st/2nd-order sigma-delta modulator with frame-aligned input select.
// Optional dither: define SD_DITHER_EN to add an LFSR bit into the input.
module sd_mod_nsel #(
   parameter int BITWIDTH = 40,
   parameter int NSEL     = 4,
   parameter int ORDER    = 2,
   parameter int FB_SHIFT = 16,
   parameter int FRAME    = 16,
   parameter logic signed [BITWIDTH-1:0] RESETVAL = '0
) (
   input logic          clk,
   input logic          reset,
   sd_mod_nsel_if.slave bus
);
   localparam int SW = (NSEL > 1) ? $clog2(NSEL) : 1;
   localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int W  = BITWIDTH + 2;

   localparam logic signed [W-1:0] MAXV = {3'b000, {(BITWIDTH-1){1'b1}}};
   localparam logic signed [W-1:0] MINV = {3'b111, {(BITWIDTH-1){1'b0}}};
   localparam logic signed [W-1:0] FBM  = {{(W-1){1'b0}}, 1'b1} << FB_SHIFT;
   localparam logic [FW-1:0]       LAST = FW'(FRAME - 1);
   localparam logic [SW:0]         NSEL_W = (SW+1)'(NSEL);

   if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("sd_mod_nsel: ORDER must be 1 or 2");
   end

   logic signed [BITWIDTH-1:0] acc1;
   logic signed [BITWIDTH-1:0] acc2;
   logic signed [BITWIDTH-1:0] acc_last;
   logic signed [BITWIDTH-1:0] x;
   logic signed [BITWIDTH-1:0] nxt1;
   logic signed [BITWIDTH-1:0] nxt2;
   logic signed [W-1:0]        fb;
   logic signed [W-1:0]        dith;
   logic signed [W-1:0]        sum1;
   logic signed [W-1:0]        sum2;
   logic                       clip1;
   logic                       clip2;
   logic                       clip;
   logic [SW-1:0]              sel_act;
   logic [SW-1:0]              sel_req;
   logic                       pending;
   logic [FW-1:0]              frame_cnt;
   logic                       sat_flag;
   logic                       sd_out;
   logic                       accept;
   logic                       sel_ok;
   logic                       wrap;

   function automatic logic signed [BITWIDTH-1:0] clamp(
      input logic signed [W-1:0] s
   );
      if (s > MAXV)
         return MAXV[BITWIDTH-1:0];
      else if (s < MINV)
         return MINV[BITWIDTH-1:0];
      else
         return s[BITWIDTH-1:0];
   endfunction

`ifdef SD_DITHER_EN
   localparam logic signed [W-1:0] DITH =
      {{(W-1){1'b0}}, 1'b1} << (FB_SHIFT - 8);

   logic [15:0] lfsr;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting right
   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (bus.en)
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign dith = lfsr[0] ? DITH : '0;
`else
   assign dith = '0;
`endif

   assign acc_last = (ORDER == 1) ? acc1 : acc2;
   assign sd_out   = ~acc_last[BITWIDTH-1];

   always_comb begin
      fb    = sd_out ? FBM : -FBM;
      x     = bus.kin[sel_act*BITWIDTH +: BITWIDTH];
      // Two guard bits hold acc + x - fb without overflow
      sum1  = {{2{acc1[BITWIDTH-1]}}, acc1}
            + {{2{x[BITWIDTH-1]}}, x} + dith - fb;
      sum2  = {{2{acc2[BITWIDTH-1]}}, acc2}
            + {{2{acc1[BITWIDTH-1]}}, acc1} - fb;
      clip1 = (sum1 > MAXV) || (sum1 < MINV);
      clip2 = (sum2 > MAXV) || (sum2 < MINV);
      clip  = clip1 || ((ORDER == 2) && clip2);
      nxt1  = clamp(sum1);
      nxt2  = clamp(sum2);
   end

   assign accept = bus.sel_valid & ~pending;
   assign sel_ok = {1'b0, bus.sel} < NSEL_W;
   assign wrap   = bus.en & (frame_cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc1      <= RESETVAL;
         acc2      <= RESETVAL;
         sel_act   <= '0;
         sel_req   <= '0;
         pending   <= 1'b0;
         frame_cnt <= '0;
         sat_flag  <= 1'b0;
      end else begin
         if (bus.en) begin
            acc1      <= nxt1;
            frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            if (ORDER == 2)
               acc2 <= nxt2;
         end
         // accept needs pending=0, so it never collides with an apply
         if (accept) begin
            if (sel_ok) begin
               sel_req <= bus.sel;
               pending <= 1'b1;
            end
         end else if (wrap && pending) begin
            sel_act <= sel_req;
            pending <= 1'b0;
         end
         if (bus.en && clip)
            sat_flag <= 1'b1;
         else if (bus.sat_clr)
            sat_flag <= 1'b0;
      end
   end

   assign bus.sel_ready = ~pending;
   assign bus.sat_flag  = sat_flag;
   assign bus.sd_out    = sd_out;
endmodule

// File: tb/tb_sd_mod_nsel.sv
// Bench for sd_mod_nsel: ORDER 1 and ORDER 2 instances driven in parallel
// and compared every cycle against an arithmetic reference model.
module tb_sd_mod_nsel;
   localparam int BW = 40;
   localparam int NS = 3;
   localparam int FS = 16;
   localparam int FR = 16;

   localparam longint MAXV = (longint'(1) <<< (BW-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (BW-1));
   localparam longint FB   = longint'(1) <<< FS;

   logic clk = 1'b0;
   logic reset;
   logic en;
   logic sel_valid;
   logic sat_clr;
   logic [1:0] sel;
   logic [NS*BW-1:0] kin;

   always #5 clk = ~clk;

   sd_mod_nsel_if #(.BITWIDTH(BW), .NSEL(NS)) if1 ();
   sd_mod_nsel_if #(.BITWIDTH(BW), .NSEL(NS)) if2 ();

   assign if1.en = en;
   assign if1.kin = kin;
   assign if1.sel = sel;
   assign if1.sel_valid = sel_valid;
   assign if1.sat_clr = sat_clr;
   assign if2.en = en;
   assign if2.kin = kin;
   assign if2.sel = sel;
   assign if2.sel_valid = sel_valid;
   assign if2.sat_clr = sat_clr;

   sd_mod_nsel #(
      .BITWIDTH(BW), .NSEL(NS), .ORDER(1),
      .FB_SHIFT(FS), .FRAME(FR)
   ) u1 (.clk(clk), .reset(reset), .bus(if1));

   sd_mod_nsel #(
      .BITWIDTH(BW), .NSEL(NS), .ORDER(2),
      .FB_SHIFT(FS), .FRAME(FR)
   ) u2 (.clk(clk), .reset(reset), .bus(if2));

   // reference model state, index 0 = ORDER 1, 1 = ORDER 2
   longint kw [NS];
   longint m_a1 [2];
   longint m_a2 [2];
   logic   m_sat [2];
   int     m_sel = 0;
   int     m_req = 0;
   int     m_fc = 0;
   logic   m_pend = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int ones1;
   int ones2;

   function automatic longint clip(longint s);
      if (s > MAXV) return MAXV;
      if (s < MINV) return MINV;
      return s;
   endfunction

   task automatic apply_kin();
      for (int i = 0; i < NS; i++)
         kin[i*BW +: BW] = kw[i][BW-1:0];
   endtask

   task automatic model_tick();
      longint xv, fbv, s1, s2, last;
      logic c;
      logic wrap;
      if (reset) begin
         for (int o = 0; o < 2; o++) begin
            m_a1[o] = 0;
            m_a2[o] = 0;
            m_sat[o] = 1'b0;
         end
         m_sel = 0;
         m_req = 0;
         m_fc = 0;
         m_pend = 1'b0;
         return;
      end
      wrap = en && (m_fc == FR-1);
      for (int o = 0; o < 2; o++) begin
         if (en) begin
            xv = kw[m_sel];
            last = (o == 0) ? m_a1[o] : m_a2[o];
            fbv = (last >= 0) ? FB : -FB;
            s1 = m_a1[o] + xv - fbv;
            s2 = m_a2[o] + m_a1[o] - fbv;
            c = (s1 != clip(s1)) || (o == 1 && s2 != clip(s2));
            m_a1[o] = clip(s1);
            if (o == 1) m_a2[o] = clip(s2);
         end else begin
            c = 1'b0;
         end
         if (c) m_sat[o] = 1'b1;
         else if (sat_clr) m_sat[o] = 1'b0;
      end
      if (en) m_fc = (m_fc + 1) % FR;
      if (sel_valid && !m_pend) begin
         if (int'(sel) < NS) begin
            m_req = int'(sel);
            m_pend = 1'b1;
         end
      end else if (wrap && m_pend) begin
         m_sel = m_req;
         m_pend = 1'b0;
      end
   endtask

   task automatic chk(string tag, logic obs, logic expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b t=%0t",
                tag, obs, expv, $time);
      end
   endtask

   task automatic check_all();
      chk("sd_out_o1", if1.sd_out, m_a1[0] >= 0);
      chk("sd_out_o2", if2.sd_out, m_a2[1] >= 0);
      chk("sel_ready_o1", if1.sel_ready, !m_pend);
      chk("sel_ready_o2", if2.sel_ready, !m_pend);
      chk("sat_flag_o1", if1.sat_flag, m_sat[0]);
      chk("sat_flag_o2", if2.sat_flag, m_sat[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      for (int o = 0; o < 2; o++) begin
         m_a1[o] = 0;
         m_a2[o] = 0;
         m_sat[o] = 1'b0;
      end
      for (int i = 0; i < NS; i++) kw[i] = 0;
      apply_kin();
      reset = 1'b1;
      en = 1'b0;
      sel_valid = 1'b0;
      sel = '0;
      sat_clr = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("reset_sd_out", if2.sd_out, 1'b1);
      chk("reset_ready", if2.sel_ready, 1'b1);
      chk("reset_sat", if2.sat_flag, 1'b0);

      // zero input: ORDER 1 alternates, half ones
      en = 1'b1;
      ones1 = 0;
      repeat (64) begin
         step();
         ones1 += int'(if1.sd_out);
      end
      chk("zero_density_o1", ones1 == 32, 1'b1);

      // +2^15 input: 75% density
      do_reset();
      kw[0] = longint'(1) <<< 15;
      apply_kin();
      ones1 = 0;
      ones2 = 0;
      repeat (64) begin
         step();
         ones1 += int'(if1.sd_out);
         ones2 += int'(if2.sd_out);
      end
      chk("dens75_o1", ones1 >= 47 && ones1 <= 49, 1'b1);
      chk("dens75_o2", ones2 >= 46 && ones2 <= 50, 1'b1);

      // select request at frame_cnt 5, second request ignored
      kw[1] = -(longint'(1) <<< 14);
      kw[2] = longint'(3) <<< 14;
      apply_kin();
      for (int g = 0; g < 32 && m_fc != 5; g++) step();
      sel = 2'd2;
      sel_valid = 1'b1;
      step();
      chk("req_busy", if2.sel_ready, 1'b0);
      sel = 2'd1;
      step();
      sel_valid = 1'b0;
      repeat (8) step();
      chk("still_busy", if1.sel_ready, 1'b0);
      step();
      chk("applied_ready", if1.sel_ready, 1'b1);
      repeat (20) step();

      // out-of-range select is dropped
      sel = 2'd3;
      sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
      chk("bad_sel_ready", if2.sel_ready, 1'b1);

      // randomized traffic
      repeat (400) begin
         en = ($urandom_range(0, 9) != 0);
         sel_valid = ($urandom_range(0, 4) == 0);
         sel = 2'($urandom_range(0, 3));
         sat_clr = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 15) == 0) begin
            for (int i = 0; i < NS; i++)
               kw[i] = longint'($urandom_range(0, 1 << 18)) - (1 << 17);
            apply_kin();
         end
         step();
      end
      sel_valid = 1'b0;
      sat_clr = 1'b0;

      // positive saturation, sticky flag, clear, set-wins
      do_reset();
      en = 1'b1;
      kw[0] = MAXV;
      apply_kin();
      repeat (8) step();
      chk("sat_set_o1", if1.sat_flag, 1'b1);
      chk("sat_set_o2", if2.sat_flag, 1'b1);
      en = 1'b0;
      sat_clr = 1'b1;
      step();
      chk("sat_clr_o1", if1.sat_flag, 1'b0);
      en = 1'b1;
      step();
      chk("sat_setwins_o1", if1.sat_flag, 1'b1);
      sat_clr = 1'b0;
      kw[0] = MINV;
      apply_kin();
      repeat (40) step();

      // reset while a request is pending, then freeze with en=0
      do_reset();
      kw[0] = longint'(1) <<< 13;
      kw[1] = -(longint'(1) <<< 15);
      apply_kin();
      for (int g = 0; g < 32 && m_fc != 9; g++) step();
      sel = 2'd1;
      sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
      chk("pend_before_rst", if2.sel_ready, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_ready", if2.sel_ready, 1'b1);
      repeat (5) step();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sel_valid = (i == 3);
         step();
      end
      sel_valid = 1'b0;
      en = 1'b1;
      repeat (40) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
